pc_fetch_unit: RTL and testbench

Program-counter register and instruction-fetch sequencer for the LEGv8 core.
- Drives pc_inc (PC + 4) into the PCinc leg of the 12-bit 2:1 next-PC mux.
- Consumes the mux output (next_pc) as its next PC.
- Fetches instructions from instruction memory with a req/ready handshake.
- Presents fetched instructions to decode with a valid/ready handshake.
- Supports stall and a flush redirect.

---
 rtl/pc_fetch_unit.sv | 85 ++++++++
 tb/tb_pc_fetch_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: LEGv8 program counter and instruction-fetch sequencer.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   next_pc -> pc, pc_inc      next-PC mux input / current PC and PC+PC_STEP
//   stall, flush, flush_pc     hazard stall (masks imem_req) and redirect
//   imem_req/addr/ready/rdata  instruction memory request/response handshake
//   if_valid/instr/pc/ready    fetched instruction presented to decode
module pc_fetch_unit #(
    parameter int                  PC_WIDTH    = 12,
    parameter int                  INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter int                  PC_STEP     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [PC_WIDTH-1:0]    next_pc,
    output logic [PC_WIDTH-1:0]    pc_inc,
    output logic [PC_WIDTH-1:0]    pc,
    input  logic                   stall,
    input  logic                   flush,
    input  logic [PC_WIDTH-1:0]    flush_pc,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ready,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic                   if_valid,
    output logic [INSTR_WIDTH-1:0] if_instr,
    output logic [PC_WIDTH-1:0]    if_pc,
    input  logic                   if_ready
);
    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
    localparam logic [PC_WIDTH-1:0] ALIGN = ~PC_WIDTH'(3);
    state_t                 state, state_nx;
    logic [PC_WIDTH-1:0]    pc_nx, if_pc_nx;
    logic [INSTR_WIDTH-1:0] if_instr_nx;
    logic                   if_valid_nx, capture;
    assign pc_inc    = pc + PC_WIDTH'(PC_STEP);
    assign imem_addr = pc;
    assign imem_req  = (state == REQ) && !stall;
    assign capture   = imem_req && imem_ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            if_valid <= 1'b0;
            if_instr <= '0;
            if_pc    <= '0;
        end else begin
            state    <= state_nx;
            pc       <= pc_nx;
            if_valid <= if_valid_nx;
            if_instr <= if_instr_nx;
            if_pc    <= if_pc_nx;
        end
    end
    // Flush wins over both handshakes: a same-cycle response is dropped.
    always_comb begin
        state_nx    = state;
        pc_nx       = pc;
        if_valid_nx = if_valid;
        if_instr_nx = if_instr;
        if_pc_nx    = if_pc;
        if (flush) begin
            state_nx    = REQ;
            pc_nx       = flush_pc & ALIGN;
            if_valid_nx = 1'b0;
        end else begin
            case (state)
                IDLE: state_nx = REQ;
                REQ: if (capture) begin
                    state_nx    = HOLD;
                    pc_nx       = next_pc & ALIGN;
                    if_valid_nx = 1'b1;
                    if_instr_nx = imem_rdata;
                    if_pc_nx    = pc;
                end
                HOLD: if (if_ready) begin
                    state_nx    = REQ;
                    if_valid_nx = 1'b0;
                end
                default: state_nx = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed plus randomized check of pc_fetch_unit against a behavioural model.
// Ports: none (top-level bench driving clk, rst_n and all DUT inputs).
module tb_pc_fetch_unit;
    logic        clk = 0, rst_n = 0, stall = 0, flush = 0, imem_ready = 0, if_ready = 0;
    logic [11:0] next_pc = 0, flush_pc = 0;
    logic [31:0] imem_rdata = 0;
    logic [11:0] pc_inc, pc, imem_addr, if_pc;
    logic        imem_req, if_valid;
    logic [31:0] if_instr;
    int cmp = 0, bad = 0;
    bit run = 0;
    // model: phase 0 = waiting one cycle after reset, 1 = fetching, 2 = holding for decode
    int          m_ph;
    logic [11:0] m_pc, m_ifpc;
    logic [31:0] m_instr;
    logic        m_v;

    pc_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .next_pc(next_pc), .pc_inc(pc_inc), .pc(pc),
        .stall(stall), .flush(flush), .flush_pc(flush_pc), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        cmp++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph = 0; m_pc = 12'h000; m_v = 0; m_instr = 0; m_ifpc = 0;
        end else if (flush) begin
            m_pc = {flush_pc[11:2], 2'b00}; m_v = 0; m_ph = 1;
        end else if (m_ph == 0) begin
            m_ph = 1;
        end else if (m_ph == 1) begin
            if (!stall && imem_ready) begin
                m_instr = imem_rdata; m_ifpc = m_pc; m_v = 1;
                m_pc = {next_pc[11:2], 2'b00}; m_ph = 2;
            end
        end else if (if_ready) begin
            m_v = 0; m_ph = 1;
        end
    end

    always @(negedge clk) if (run) begin
        chk("pc", 32'(pc), 32'(m_pc));
        chk("pc_inc", 32'(pc_inc), 32'((m_pc + 12'd4) % 4096));
        chk("imem_addr", 32'(imem_addr), 32'(m_pc));
        chk("imem_req", 32'(imem_req), 32'(m_ph == 1 && !stall));
        chk("if_valid", 32'(if_valid), 32'(m_v));
        chk("if_instr", if_instr, m_instr);
        chk("if_pc", 32'(if_pc), 32'(m_ifpc));
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_pc", 32'(pc), 32'h000);
        chk("rst_pc_inc", 32'(pc_inc), 32'h004);
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_valid", 32'(if_valid), 32'h0);
        run = 1;
        rst_n = 1;
        @(negedge clk); chk("idle_req", 32'(imem_req), 32'h0);
        tick();
        for (int k = 0; k < 3; k++) begin
            next_pc = (k == 2) ? 12'h0A2 : 12'(4 * k + 4);
            imem_rdata = 32'hA0000000 + 32'(4 * k); imem_ready = 1; if_ready = 1;
            @(negedge clk);
            chk("seq_req", 32'(imem_req), 32'h1);
            chk("seq_addr", 32'(imem_addr), 32'(4 * k));
            tick();
            @(negedge clk);
            chk("seq_valid", 32'(if_valid), 32'h1);
            chk("seq_if_pc", 32'(if_pc), 32'(4 * k));
            chk("seq_instr", if_instr, 32'hA0000000 + 32'(4 * k));
            chk("seq_pc", 32'(pc), (k == 2) ? 32'h0A0 : 32'(4 * k + 4));
            tick();
        end
        imem_ready = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("wait_req", 32'(imem_req), 32'h1);
            chk("wait_addr", 32'(imem_addr), 32'h0A0);
            chk("wait_valid", 32'(if_valid), 32'h0);
            tick();
        end
        stall = 1; imem_ready = 1; imem_rdata = 32'h12345678;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("stall_req", 32'(imem_req), 32'h0);
            chk("stall_valid", 32'(if_valid), 32'h0);
            tick();
        end
        stall = 0; imem_rdata = 32'hDEADBEEF; next_pc = 12'h0A4; if_ready = 0;
        tick();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_valid", 32'(if_valid), 32'h1);
            chk("bp_if_pc", 32'(if_pc), 32'h0A0);
            chk("bp_instr", if_instr, 32'hDEADBEEF);
            chk("bp_req", 32'(imem_req), 32'h0);
            tick();
        end
        if_ready = 1; imem_ready = 0;
        tick();
        @(negedge clk);
        chk("bp_rel_valid", 32'(if_valid), 32'h0);
        chk("bp_rel_req", 32'(imem_req), 32'h1);
        chk("bp_rel_addr", 32'(imem_addr), 32'h0A4);
        flush = 1; flush_pc = 12'h101; imem_ready = 1; imem_rdata = 32'hBAD0BAD0;
        tick();
        flush = 0; imem_ready = 0;
        @(negedge clk);
        chk("flush_valid", 32'(if_valid), 32'h0);
        chk("flush_addr", 32'(imem_addr), 32'h100);
        flush = 1; flush_pc = 12'hFFE;
        tick();
        flush = 0;
        @(negedge clk);
        chk("wrap_pc", 32'(pc), 32'hFFC);
        chk("wrap_pc_inc", 32'(pc_inc), 32'h000);
        imem_ready = 1; if_ready = 0; next_pc = 12'h000; imem_rdata = 32'h0BADF00D;
        tick();
        @(negedge clk);
        chk("hold_if_pc", 32'(if_pc), 32'hFFC);
        #2 rst_n = 0; #1;
        chk("arst_pc", 32'(pc), 32'h000);
        chk("arst_pc_inc", 32'(pc_inc), 32'h004);
        chk("arst_valid", 32'(if_valid), 32'h0);
        chk("arst_req", 32'(imem_req), 32'h0);
        chk("arst_if_pc", 32'(if_pc), 32'h000);
        chk("arst_instr", if_instr, 32'h0);
        tick();
        rst_n = 1;
        for (int i = 0; i < 4000; i++) begin
            stall      = ($urandom_range(0, 3) == 0);
            flush      = ($urandom_range(0, 15) == 0);
            flush_pc   = 12'($urandom);
            imem_ready = $urandom_range(0, 1) == 1;
            imem_rdata = $urandom;
            if_ready   = $urandom_range(0, 1) == 1;
            next_pc    = ($urandom_range(0, 1) == 1) ? m_pc + 12'd4 : 12'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                rst_n = 0; #2; rst_n = 1;
            end
            tick();
        end
        @(negedge clk);
        run = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule
